// File: rtl/sonic_vc_demux_n.sv
// Packet-locked Avalon-ST channel demux: 1-entry input stage feeding one 1-entry stage per output.
// Optional drop counter enabled by defining SONIC_VC_DEMUX_DROP_CNT_EN.
module sonic_vc_demux_n #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned EMPTY_W = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
  output logic [15:0]                 drop_count,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH_W-1:0]             in_channel,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_startofpacket,
  input  logic                        in_endofpacket,
  input  logic [EMPTY_W-1:0]          in_empty,
  output logic [NUM_CH-1:0]           out_valid,
  input  logic [NUM_CH-1:0]           out_ready,
  output logic [NUM_CH*DATA_W-1:0]    out_data,
  output logic [NUM_CH-1:0]           out_startofpacket,
  output logic [NUM_CH-1:0]           out_endofpacket,
  output logic [NUM_CH*EMPTY_W-1:0]   out_empty
);

  logic                      rdy_en_q;
  logic                      stg_valid_q, stg_valid_d;
  logic [DATA_W-1:0]         stg_data_q, stg_data_d;
  logic                      stg_sop_q, stg_sop_d;
  logic                      stg_eop_q, stg_eop_d;
  logic [EMPTY_W-1:0]        stg_empty_q, stg_empty_d;
  logic [CH_W-1:0]           stg_ch_q, stg_ch_d;
  logic                      pkt_q, pkt_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [NUM_CH-1:0]         ov_q, ov_d;
  logic [NUM_CH*DATA_W-1:0]  od_q, od_d;
  logic [NUM_CH-1:0]         osop_q, osop_d;
  logic [NUM_CH-1:0]         oeop_q, oeop_d;
  logic [NUM_CH*EMPTY_W-1:0] oemp_q, oemp_d;

  logic [NUM_CH-1:0]         oready;
  logic                      stg_take;
  logic                      in_ready_c;
  logic                      accept;
  logic [CH_W-1:0]           route_ch;
  logic                      route_bad;
  logic                      orphan;
  logic                      drop_ev;

  // Routing, input-stage and output-stage next state.
  always_comb begin
    oready      = out_ready | ~ov_q;
    stg_take    = 1'b0;
    pkt_d       = pkt_q;
    ch_d        = ch_q;
    stg_data_d  = stg_data_q;
    stg_sop_d   = stg_sop_q;
    stg_eop_d   = stg_eop_q;
    stg_empty_d = stg_empty_q;
    stg_ch_d    = stg_ch_q;
    ov_d        = ov_q & ~out_ready;
    od_d        = od_q;
    osop_d      = osop_q;
    oeop_d      = oeop_q;
    oemp_d      = oemp_q;

    for (int i = 0; i < NUM_CH; i++) begin
      if (stg_valid_q && stg_ch_q == CH_W'(i) && oready[i]) begin
        stg_take = 1'b1;
      end
    end

    in_ready_c  = rdy_en_q & (~stg_valid_q | stg_take);
    accept      = in_valid & in_ready_c;
    route_ch    = in_startofpacket ? in_channel : ch_q;
    route_bad   = 32'(route_ch) >= NUM_CH;
    orphan      = ~in_startofpacket & ~pkt_q;
    drop_ev     = accept & (orphan | (in_startofpacket & route_bad));
    stg_valid_d = stg_valid_q & ~stg_take;

    if (accept) begin
      if (in_startofpacket) begin
        ch_d  = in_channel;
        pkt_d = ~in_endofpacket;
      end else if (pkt_q) begin
        pkt_d = ~in_endofpacket;
      end
      if (!(orphan || route_bad)) begin
        stg_valid_d = 1'b1;
        stg_data_d  = in_data;
        stg_sop_d   = in_startofpacket;
        stg_eop_d   = in_endofpacket;
        stg_empty_d = in_empty;
        stg_ch_d    = route_ch;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (stg_take && stg_ch_q == CH_W'(i)) begin
        ov_d[i]                        = 1'b1;
        od_d[i*DATA_W +: DATA_W]       = stg_data_q;
        osop_d[i]                      = stg_sop_q;
        oeop_d[i]                      = stg_eop_q;
        oemp_d[i*EMPTY_W +: EMPTY_W]   = stg_empty_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q    <= 1'b0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_sop_q   <= 1'b0;
      stg_eop_q   <= 1'b0;
      stg_empty_q <= '0;
      stg_ch_q    <= '0;
      pkt_q       <= 1'b0;
      ch_q        <= '0;
      ov_q        <= '0;
      od_q        <= '0;
      osop_q      <= '0;
      oeop_q      <= '0;
      oemp_q      <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      stg_sop_q   <= stg_sop_d;
      stg_eop_q   <= stg_eop_d;
      stg_empty_q <= stg_empty_d;
      stg_ch_q    <= stg_ch_d;
      pkt_q       <= pkt_d;
      ch_q        <= ch_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      osop_q      <= osop_d;
      oeop_q      <= oeop_d;
      oemp_q      <= oemp_d;
    end
  end

`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded packets and orphan beats.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_ev && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop_ev;
`endif

  assign in_ready          = in_ready_c;
  assign out_valid         = ov_q;
  assign out_data          = od_q;
  assign out_startofpacket = osop_q;
  assign out_endofpacket   = oeop_q;
  assign out_empty         = oemp_q;

endmodule

// File: tb/tb_sonic_vc_demux_n.sv
// Bench for sonic_vc_demux_n (NUM_CH=3, CH_W=2): scoreboard of expected beats per channel plus directed literals.
module tb_sonic_vc_demux_n;
  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EMPTY_W = 2;
  localparam int unsigned PL_W    = DATA_W + EMPTY_W + 2;

  logic                      clk, reset_n;
  logic                      in_valid, in_ready;
  logic [CH_W-1:0]           in_channel;
  logic [DATA_W-1:0]         in_data;
  logic                      in_startofpacket, in_endofpacket;
  logic [EMPTY_W-1:0]        in_empty;
  logic [NUM_CH-1:0]         out_valid, out_ready;
  logic [NUM_CH*DATA_W-1:0]  out_data;
  logic [NUM_CH-1:0]         out_startofpacket, out_endofpacket;
  logic [NUM_CH*EMPTY_W-1:0] out_empty;
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
  logic [15:0]               drop_count;
`endif

  sonic_vc_demux_n #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty)
  );

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] emp;
    logic [DATA_W-1:0]  data;
  } beat_t;

  beat_t           exp_q[$];
  int              nvec = 0;
  int              nerr = 0;
  int              deliv[NUM_CH];
  int              exp_drop;
  bit              m_pkt;
  logic [CH_W-1:0] m_ch;
  logic [NUM_CH-1:0] hold_prev;
  logic [PL_W-1:0] prev_pl[NUM_CH];
  int              idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PL_W-1:0] pl(input int i);
    return {out_startofpacket[i], out_endofpacket[i],
            out_empty[i*EMPTY_W +: EMPTY_W], out_data[i*DATA_W +: DATA_W]};
  endfunction

  // Reference model: routing rules applied per accepted beat, checked at output handshakes.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_pkt     = 1'b0;
      m_ch      = '0;
      exp_drop  = 0;
      hold_prev = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hold_prev[i]) begin
          chk("hold_valid", 64'(out_valid[i]), 64'd1);
          chk("hold_payload", 64'(pl(i)), 64'(prev_pl[i]));
        end
        if (out_valid[i] && out_ready[i]) begin
          idx = -1;
          foreach (exp_q[j]) if (idx < 0 && 32'(exp_q[j].ch) == i) idx = j;
          if (idx < 0) begin
            chk("unexpected_beat", 64'(out_valid[i]), 64'd0);
          end else begin
            chk("beat", 64'(pl(i)), 64'({exp_q[idx].sop, exp_q[idx].eop, exp_q[idx].emp, exp_q[idx].data}));
            exp_q.delete(idx);
            deliv[i]++;
          end
        end
        hold_prev[i] = out_valid[i] & ~out_ready[i];
        prev_pl[i]   = pl(i);
      end
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
      chk("drop_count", 64'(drop_count), 64'(exp_drop));
`endif
      if (in_valid && in_ready) begin
        if (in_startofpacket) begin
          m_ch  = in_channel;
          m_pkt = !in_endofpacket;
          if (32'(in_channel) >= NUM_CH) begin
            if (exp_drop < 65535) exp_drop++;
          end else begin
            exp_q.push_back('{in_channel, 1'b1, in_endofpacket, in_empty, in_data});
          end
        end else if (m_pkt) begin
          if (32'(m_ch) < NUM_CH)
            exp_q.push_back('{m_ch, 1'b0, in_endofpacket, in_empty, in_data});
          m_pkt = !in_endofpacket;
        end else begin
          if (exp_drop < 65535) exp_drop++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic sop, input logic eop, input logic [CH_W-1:0] ch,
                          input logic [DATA_W-1:0] d, input logic [EMPTY_W-1:0] e);
    in_valid = v; in_startofpacket = sop; in_endofpacket = eop;
    in_channel = ch; in_data = d; in_empty = e;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [CH_W-1:0] ch,
                      input logic [DATA_W-1:0] d, input logic [EMPTY_W-1:0] e);
    int n;
    set_beat(1'b1, sop, eop, ch, d, e);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      n++;
      step();
    end
    repeat (2) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  int d0, d1, d2;

  initial begin
    reset_n = 1'b0;
    out_ready = '1;
    set_beat(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data[63:0]), 64'd0);
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    chk("rst_drop", 64'(drop_count), 64'd0);
`endif
    step();
    reset_n = 1'b1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    chk("in_ready_first_edge", 64'(in_ready), 64'd1);

    // 3-beat packet on channel 2, two-register latency.
    set_beat(1'b1, 1'b1, 1'b0, 2'd2, 32'hA000_0001, 2'd0);
    step();
    chk("lat_k", 64'(out_valid), 64'd0);
    set_beat(1'b1, 1'b0, 1'b0, 2'd2, 32'hA000_0002, 2'd0);
    step();
    chk("b1_valid", 64'(out_valid), 64'b100);
    chk("b1_data", 64'(out_data[64 +: 32]), 64'hA000_0001);
    chk("b1_sop", 64'(out_startofpacket), 64'b100);
    set_beat(1'b1, 1'b0, 1'b1, 2'd2, 32'hA000_0003, 2'd3);
    step();
    chk("b2_valid", 64'(out_valid), 64'b100);
    chk("b2_data", 64'(out_data[64 +: 32]), 64'hA000_0002);
    chk("b2_sopeop", 64'({out_startofpacket[2], out_endofpacket[2]}), 64'b00);
    set_beat(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    chk("b3_data", 64'(out_data[64 +: 32]), 64'hA000_0003);
    chk("b3_eop", 64'(out_endofpacket), 64'b100);
    chk("b3_empty", 64'(out_empty[4 +: 2]), 64'd3);
    step();
    chk("idle_after_pkt", 64'(out_valid), 64'd0);
    drain();

    // Channel latched on SOP; in_channel on later beats is ignored.
    d0 = deliv[0]; d1 = deliv[1]; d2 = deliv[2];
    send(1'b1, 1'b0, 2'd1, 32'hB000_0001, 2'd1);
    send(1'b0, 1'b0, 2'd3, 32'hB000_0002, 2'd2);
    send(1'b0, 1'b1, 2'd3, 32'hB000_0003, 2'd1);
    drain();
    chk("lock_out1", 64'(deliv[1] - d1), 64'd3);
    chk("lock_others", 64'((deliv[0] - d0) + (deliv[2] - d2)), 64'd0);

    // Out-of-range channel: accepted and discarded, one drop event.
    d0 = deliv[0]; d1 = deliv[1]; d2 = deliv[2];
    set_beat(1'b1, 1'b1, 1'b0, 2'd3, 32'hC000_0001, 2'd0);
    @(negedge clk); chk("bad_rdy1", 64'(in_ready), 64'd1); step();
    set_beat(1'b1, 1'b0, 1'b1, 2'd0, 32'hC000_0002, 2'd0);
    @(negedge clk); chk("bad_rdy2", 64'(in_ready), 64'd1); step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("bad_no_out", 64'((deliv[0] - d0) + (deliv[1] - d1) + (deliv[2] - d2)), 64'd0);
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    chk("bad_drop", 64'(drop_count), 64'd1);
`endif

    // Single-beat packet followed by new SOP mid-packet on another channel.
    send(1'b1, 1'b1, 2'd0, 32'hD000_0001, 2'd2);
    send(1'b1, 1'b0, 2'd1, 32'hD000_0002, 2'd0);
    send(1'b1, 1'b1, 2'd2, 32'hD000_0003, 2'd1);
    drain();

    // Stalled channel 0 blocks the input stage; release gives ordered delivery.
    out_ready = 3'b110;
    fork
      begin
        send(1'b1, 1'b0, 2'd0, 32'hE000_0001, 2'd0);
        send(1'b0, 1'b1, 2'd0, 32'hE000_0002, 2'd1);
        send(1'b1, 1'b1, 2'd1, 32'hE000_0003, 2'd2);
      end
      begin
        repeat (6) step();
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'b001);
        chk("stall_out0", 64'(out_data[0 +: 32]), 64'hE000_0001);
        out_ready = '1;
      end
    join
    drain();

    // Orphan beat after reset; optional saturation.
    do_reset();
    d1 = deliv[1];
    send(1'b0, 1'b1, 2'd1, 32'hF000_0001, 2'd0);
    step();
    chk("orphan_no_out", 64'(deliv[1] - d1), 64'd0);
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    chk("orphan_drop", 64'(drop_count), 64'd1);
    set_beat(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0);
    repeat (65540) step();
    in_valid = 1'b0;
    step();
    chk("drop_saturate", 64'(drop_count), 64'hFFFF);
`endif

    // Reset mid-packet.
    out_ready = 3'b101;
    send(1'b1, 1'b0, 2'd1, 32'h1111_0001, 2'd0);
    send(1'b0, 1'b0, 2'd1, 32'h1111_0002, 2'd0);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
`endif
    out_ready = '1;
    step();
    reset_n = 1'b1;
    step();
    chk("mid_rst_ready_edge", 64'(in_ready), 64'd1);
    d1 = deliv[1];
    send(1'b0, 1'b1, 2'd1, 32'h1111_0003, 2'd0);
    repeat (3) step();
    chk("mid_rst_orphan", 64'(deliv[1] - d1), 64'd0);
`ifdef SONIC_VC_DEMUX_DROP_CNT_EN
    chk("mid_rst_orphan_drop", 64'(drop_count), 64'd1);
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
